// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse_gen pulse-train generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Smallest period that still leaves one low cycle between pulses
    localparam int MIN_PERIOD = 2;
    // Shortest high phase the counter can see
    localparam int MIN_HIGH   = 1;

endpackage

// File: rtl/pulse_gen_timer.sv
// Loadable down-counter shared by the HIGH and LOW phases.
// It stops at zero (no wrap); expire is high while the count is zero.
module pulse_gen_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: N pulses with a clamped period and
// high time, start/busy/done handshake, abort.
// Optional feature macro: PULSE_GEN_CONTINUOUS_EN (n_pulses==0 runs until
// abort, sent wraps instead of saturating).
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter int N_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_W-1:0]   n_pulses,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_time,
    output logic             pulso,
    output logic             busy,
    output logic             done,
    output logic [N_W-1:0]   sent
);

`ifdef PULSE_GEN_CONTINUOUS_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    state_t           state, state_n;
    logic [N_W-1:0]   n_lat;
    logic [CNT_W-1:0] hi_lat, lo_lat;
    logic [CNT_W-1:0] per_eff, hi_eff, lo_eff;
    logic [N_W-1:0]   sent_inc;
    logic             load, expire, more;
    logic [CNT_W-1:0] load_val;

    // Clamp the requested timing so every pulse has >=1 high and >=1 low cycle
    always_comb begin
        per_eff = period;
        if (period < CNT_W'(MIN_PERIOD))
            per_eff = CNT_W'(MIN_PERIOD);
        hi_eff = high_time;
        if (high_time < CNT_W'(MIN_HIGH))
            hi_eff = CNT_W'(MIN_HIGH);
        else if (high_time > per_eff - CNT_W'(1))
            hi_eff = per_eff - CNT_W'(1);
        lo_eff = per_eff - hi_eff;
    end

    // Saturating count in burst mode, wrapping count in continuous mode
    always_comb begin
        sent_inc = sent + 1'b1;
        if (!CONT_EN && sent == '1)
            sent_inc = sent;
    end

    // A zero latched count only reaches LOW in continuous mode
    assign more = (CONT_EN && n_lat == '0) || (sent < n_lat);

    // Next-state logic; the timer reloads on every entry into HIGH or LOW
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start && !abort)
                      state_n = (n_pulses != '0 || CONT_EN) ? HIGH : DONE;
            HIGH: if (abort)       state_n = DONE;
                  else if (expire) state_n = LOW;
            LOW:  if (abort)       state_n = DONE;
                  else if (expire) state_n = more ? HIGH : DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        load     = (state_n == HIGH || state_n == LOW) && (state_n != state);
        load_val = lo_lat - CNT_W'(1);
        if (state_n == HIGH)
            load_val = ((state == IDLE) ? hi_eff : hi_lat) - CNT_W'(1);
    end

    pulse_gen_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // State, registered outputs, latched config and sent counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pulso  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sent   <= '0;
            n_lat  <= '0;
            hi_lat <= '0;
            lo_lat <= '0;
        end else begin
            state <= state_n;
            pulso <= (state_n == HIGH);
            busy  <= (state_n == HIGH) || (state_n == LOW);
            done  <= (state_n == DONE);
            if (state == IDLE && state_n != IDLE) begin
                n_lat  <= n_pulses;
                hi_lat <= hi_eff;
                lo_lat <= lo_eff;
                sent   <= (state_n == HIGH) ? N_W'(1) : '0;
            end else if (state == LOW && state_n == HIGH) begin
                sent <= sent_inc;
            end
        end
    end

endmodule
